// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants for the scoreboarded register file: default widths and
// the indices of the hardwired / special registers.
//   REG0 : index that always reads as zero and ignores writes
//   PC   : index whose reads return the live PcAddr0 input
//   T    : index whose writes store a zero-test flag instead of the data
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NRD    = 2;

    localparam int REG0     = 0;
    localparam int PC       = 1;
    localparam int T        = 2;
    localparam int DEF_PEEK = 7;

endpackage

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port: selects the operand and its ready flag.
// Ports:
//   RegFlat    : all stored registers, register i at [i*DATA_W +: DATA_W]
//   Busy       : scoreboard busy bit per register
//   RegWre     : write enable of the current cycle (for bypass)
//   WriteReg   : write index of the current cycle
//   WriteValue : value that will be stored this cycle (T conversion done)
//   PcAddr0    : value returned for PC reads
//   RdAddr     : index to read
//   RdData     : operand value
//   RdReady    : operand is valid (not waiting on an outstanding producer)
// ---------------------------------------------------------------------------
module regfile_rdport
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_IDX = REG0,
    parameter int PC_IDX   = PC
) (
    input  logic [(2**ADDR_W)*DATA_W-1:0] RegFlat,
    input  logic [(2**ADDR_W)-1:0]        Busy,
    input  logic                          RegWre,
    input  logic [ADDR_W-1:0]             WriteReg,
    input  logic [DATA_W-1:0]             WriteValue,
    input  logic [DATA_W-1:0]             PcAddr0,
    input  logic [ADDR_W-1:0]             RdAddr,
    output logic [DATA_W-1:0]             RdData,
    output logic                          RdReady
);

    logic [DATA_W-1:0] storedValue;

    // Stored copy of the addressed register, used when nothing overrides it.
    assign storedValue = RegFlat[int'(RdAddr)*DATA_W +: DATA_W];

    // Hardwired indices come first so that a write aimed at them can never
    // leak through the bypass. A same-cycle write is forwarded and is always
    // ready, because its data is exactly what the waiting consumer needs.
    always_comb begin
        RdData  = storedValue;
        RdReady = ~Busy[RdAddr];
        if (RdAddr == ADDR_W'(ZERO_IDX)) begin
            RdData  = '0;
            RdReady = 1'b1;
        end else if (RdAddr == ADDR_W'(PC_IDX)) begin
            RdData  = PcAddr0;
            RdReady = 1'b1;
        end else if (RegWre && (WriteReg == RdAddr)) begin
            RdData  = WriteValue;
            RdReady = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Register file with a per-register busy scoreboard, write-through bypass
// and NRD combinational read ports.
// Ports:
//   Clk       : clock, all state changes on the rising edge
//   Rst       : asynchronous active-low reset, clears data and busy bits
//   RegWre    : write enable          WriteReg / WriteData : write index/data
//   ResWre    : reserve enable        ResReg : index to mark busy
//   Flush     : clear every busy bit
//   PcAddr0   : value returned for PC_IDX reads
//   RdAddr    : packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   RdData    : packed read data, port k at [k*DATA_W +: DATA_W]
//   RdReady   : per-port operand-ready flag
//   RegPeek1  : stored value of r[PEEK_IDX]
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_IDX = REG0,
    parameter int PC_IDX   = PC,
    parameter int T_IDX    = T,
    parameter int PEEK_IDX = DEF_PEEK
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    RegWre,
    input  logic [ADDR_W-1:0]       WriteReg,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic                    ResWre,
    input  logic [ADDR_W-1:0]       ResReg,
    input  logic                    Flush,
    input  logic [DATA_W-1:0]       PcAddr0,
    input  logic [NRD*ADDR_W-1:0]   RdAddr,
    output logic [NRD*DATA_W-1:0]   RdData,
    output logic [NRD-1:0]          RdReady,
    output logic [DATA_W-1:0]       RegPeek1
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]       regFile [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        busyNext;
    logic [DEPTH*DATA_W-1:0] regFlat;
    logic [DATA_W-1:0]       writeValue;
    logic                    writeAllowed;
    logic                    reserveAllowed;

    // The zero and PC slots are not real storage, so writes and reserves
    // aimed at them are dropped here and their busy bits never get set.
    assign writeAllowed   = RegWre && (WriteReg != ADDR_W'(ZERO_IDX))
                                   && (WriteReg != ADDR_W'(PC_IDX));
    assign reserveAllowed = ResWre && (ResReg != ADDR_W'(ZERO_IDX))
                                   && (ResReg != ADDR_W'(PC_IDX));

    // T holds a zero-test flag of the written value rather than the value.
    assign writeValue = (WriteReg == ADDR_W'(T_IDX))
                      ? {{(DATA_W-1){1'b0}}, (WriteData == '0)}
                      : WriteData;

    // Data storage; Flush only touches the scoreboard, never the data path.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeAllowed) begin
            regFile[WriteReg] <= writeValue;
        end
    end

    // Scoreboard next state: the write clear is applied before the reserve
    // so that a new producer reserving the same index in the same cycle
    // keeps it busy; Flush overrides both.
    always_comb begin
        busyNext = busy;
        if (Flush) begin
            busyNext = '0;
        end else begin
            if (writeAllowed) begin
                busyNext[WriteReg] = 1'b0;
            end
            if (reserveAllowed) begin
                busyNext[ResReg] = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign RegPeek1 = regFile[ADDR_W'(PEEK_IDX)];

    // Flatten storage so each read port can index it as a plain vector.
    for (genvar g = 0; g < DEPTH; g++) begin : gFlat
        assign regFlat[g*DATA_W +: DATA_W] = regFile[g];
    end

    for (genvar k = 0; k < NRD; k++) begin : gRdPort
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_IDX (ZERO_IDX),
            .PC_IDX   (PC_IDX)
        ) uRdPort (
            .RegFlat    (regFlat),
            .Busy       (busy),
            .RegWre     (writeAllowed),
            .WriteReg   (WriteReg),
            .WriteValue (writeValue),
            .PcAddr0    (PcAddr0),
            .RdAddr     (RdAddr[k*ADDR_W +: ADDR_W]),
            .RdData     (RdData[k*DATA_W +: DATA_W]),
            .RdReady    (RdReady[k])
        );
    end

endmodule
